// File: rtl/fpga_test_step_div_pkg.sv
// Shared types and helpers for the fpga_test_step sequential signed divider.
// Holds the FSM encoding, iteration constants and the dividend magnitude helper.
package fpga_test_step_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 5;

  // 33 bits so that |0x80000000| is representable without wrap.
  function automatic logic [32:0] abs33(input logic [31:0] v);
    logic [32:0] ext;
    ext = {v[31], v};
    return v[31] ? (~ext + 33'd1) : ext;
  endfunction

endpackage

// File: rtl/fpga_test_step_sdiv_stage.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
// Zero latency; no flow control (pure function of its inputs).
module fpga_test_step_sdiv_stage (
  input  logic [8:0] rem_in,
  input  logic       bit_in,
  input  logic [7:0] divisor,
  output logic [8:0] rem_out,
  output logic       q_bit
);

  logic [9:0] shifted;
  logic [9:0] divisor_ext;

  always_comb begin
    shifted     = {rem_in, bit_in};
    divisor_ext = {2'b00, divisor};
    q_bit       = (shifted >= divisor_ext);
    rem_out     = q_bit ? 9'(shifted - divisor_ext) : shifted[8:0];
  end

endmodule

// File: rtl/fpga_test_step_sdiv_32s_8ns_32_seq.sv
// Signed-32 / unsigned-8 radix-2 divider, 34 ce-cycles accept-to-done, ap_start ignored unless idle.
// Defining FPGA_TEST_STEP_SDIV_REM_EN adds the signed 9-bit rem_out port.
module fpga_test_step_sdiv_32s_8ns_32_seq
  import fpga_test_step_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  div_by_zero
`ifdef FPGA_TEST_STEP_SDIV_REM_EN
  ,
  output logic [din1_WIDTH:0]   rem_out
`endif
);

  if (din0_WIDTH != 32 || din1_WIDTH != 8 || dout_WIDTH != din0_WIDTH || ID < 0) begin : g_bad_cfg
    $error("divider datapath is fixed at 32s/8u with dout_WIDTH == din0_WIDTH");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITERS - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sign_q, sign_d;
  logic [din0_WIDTH-1:0]   mag_q, mag_d;
  logic [din1_WIDTH-1:0]   div_q, div_d;
  logic [din1_WIDTH:0]     rem_q, rem_d;
  logic [dout_WIDTH-1:0]   dout_q, dout_d;
  logic                    dbz_q, dbz_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
`ifdef FPGA_TEST_STEP_SDIV_REM_EN
  logic [din1_WIDTH:0]     rem_out_q, rem_out_d;
`endif

  logic [din1_WIDTH:0]     step_rem;
  logic                    step_q;

  // mag_q doubles as the quotient shift register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  fpga_test_step_sdiv_stage u_stage (
    .rem_in  (rem_q),
    .bit_in  (mag_q[din0_WIDTH-1]),
    .divisor (div_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    div_d   = div_q;
    rem_d   = rem_q;
    dout_d  = dout_q;
    dbz_d   = dbz_q;
    ready_d = 1'b0;
    done_d  = 1'b0;
`ifdef FPGA_TEST_STEP_SDIV_REM_EN
    rem_out_d = rem_out_q;
`endif
    case (state_q)
      IDLE: begin
        if (ap_start) begin
          sign_d  = din0[din0_WIDTH-1];
          mag_d   = din0_WIDTH'(abs33(din0));
          div_d   = din1;
          rem_d   = '0;
          cnt_d   = '0;
          ready_d = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        mag_d = {mag_q[din0_WIDTH-2:0], step_q};
        rem_d = step_rem;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = FIX;
        end
      end
      FIX: begin
        dbz_d = (div_q == '0);
        if (div_q == '0) begin
          dout_d = '0;
        end else begin
          dout_d = sign_q ? (~mag_q + 1'b1) : mag_q;
        end
`ifdef FPGA_TEST_STEP_SDIV_REM_EN
        // A zero divisor leaves the low 9 magnitude bits in rem_q, so the same
        // sign fix-up already reproduces din0[8:0].
        rem_out_d = sign_q ? (~rem_q + 1'b1) : rem_q;
`endif
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      dout_q  <= '0;
      dbz_q   <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef FPGA_TEST_STEP_SDIV_REM_EN
      rem_out_q <= '0;
`endif
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      dout_q  <= dout_d;
      dbz_q   <= dbz_d;
      ready_q <= ready_d;
      done_q  <= done_d;
`ifdef FPGA_TEST_STEP_SDIV_REM_EN
      rem_out_q <= rem_out_d;
`endif
    end
  end

  assign ap_idle     = (state_q == IDLE);
  assign ap_ready    = ready_q;
  assign ap_done     = done_q;
  assign dout        = dout_q;
  assign div_by_zero = dbz_q;
`ifdef FPGA_TEST_STEP_SDIV_REM_EN
  assign rem_out     = rem_out_q;
`endif

endmodule

// File: tb/tb_fpga_test_step_sdiv_32s_8ns_32_seq.sv
// Scoreboard bench for the sequential signed divider: C-semantics model, latency and handshake checks.
module tb_fpga_test_step_sdiv_32s_8ns_32_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ce;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_idle;
  logic        ap_done;
  logic [31:0] din0;
  logic [7:0]  din1;
  logic [31:0] dout;
  logic        div_by_zero;
`ifdef FPGA_TEST_STEP_SDIV_REM_EN
  logic [8:0]  rem_out;
`endif

  typedef struct packed {
    logic [31:0] q;
    logic        dbz;
    logic [8:0]  r;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errs    = 0;

  always #5 ap_clk = ~ap_clk;

  fpga_test_step_sdiv_32s_8ns_32_seq #(
    .ID(1), .din0_WIDTH(32), .din1_WIDTH(8), .dout_WIDTH(32)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .ce          (ce),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_idle     (ap_idle),
    .ap_done     (ap_done),
    .din0        (din0),
    .din1        (din1),
    .dout        (dout),
    .div_by_zero (div_by_zero)
`ifdef FPGA_TEST_STEP_SDIV_REM_EN
    ,
    .rem_out     (rem_out)
`endif
  );

  function automatic exp_t model(input logic [31:0] a, input logic [7:0] b);
    exp_t   e;
    longint sa, dv, q, r;
    sa = longint'($signed(a));
    dv = longint'(b);
    if (b == 8'd0) begin
      e.q   = 32'd0;
      e.dbz = 1'b1;
      e.r   = a[8:0];
    end else begin
      q     = sa / dv;
      r     = sa % dv;
      e.q   = q[31:0];
      e.dbz = 1'b0;
      e.r   = r[8:0];
    end
    return e;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (ap_idle !== 1'b1 && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    vectors++;
    if (ap_idle !== 1'b1) begin
      errs++;
      $display("FAIL idle_timeout: ap_idle=%b after %0d cycles, required 1", ap_idle, n);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic start_op(input logic [31:0] a, input logic [7:0] b);
    wait_idle();
    din0     = a;
    din1     = b;
    ap_start = 1'b1;
    sb.push_back(model(a, b));
    @(posedge ap_clk);
    @(negedge ap_clk);
    vectors++;
    if (ap_ready !== 1'b1) begin
      errs++;
      $display("FAIL ap_ready_pulse: got %b, required 1 (din0=%h din1=%h)", ap_ready, a, b);
    end
    ap_start = 1'b0;
    din0     = $urandom;
    din1     = 8'($urandom);
  endtask

  // cyc0 = edges already elapsed since the accept edge.
  task automatic wait_done(input int cyc0, input int exp_lat, input string name);
    int   cyc;
    exp_t e;
    cyc = cyc0;
    while (ap_done !== 1'b1 && cyc < exp_lat + 20) begin
      @(posedge ap_clk);
      cyc++;
      @(negedge ap_clk);
    end
    vectors++;
    if (ap_done !== 1'b1 || cyc != exp_lat) begin
      errs++;
      $display("FAIL %s_latency: ap_done=%b at %0d cycles, required 1 at %0d", name, ap_done, cyc, exp_lat);
    end
    vectors++;
    if (sb.size() == 0) begin
      errs++;
      $display("FAIL %s_scoreboard: queue empty at ap_done, required one pending result", name);
    end else begin
      e = sb.pop_front();
      if (dout !== e.q || div_by_zero !== e.dbz) begin
        errs++;
        $display("FAIL %s_result: dout=%h dbz=%b, required dout=%h dbz=%b", name, dout, div_by_zero, e.q, e.dbz);
      end
`ifdef FPGA_TEST_STEP_SDIV_REM_EN
      vectors++;
      if (rem_out !== e.r) begin
        errs++;
        $display("FAIL %s_rem: rem_out=%h, required %h", name, rem_out, e.r);
      end
`endif
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; ce = 1'b0; ap_start = 1'b0; din0 = '0; din1 = '0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    vectors++;
    if (ap_idle !== 1'b1) begin errs++; $display("FAIL reset_idle: got %b, required 1", ap_idle); end
    vectors++;
    if (ap_ready !== 1'b0 || ap_done !== 1'b0) begin
      errs++; $display("FAIL reset_pulses: ready=%b done=%b, required 0 0", ap_ready, ap_done);
    end
    vectors++;
    if (dout !== 32'd0 || div_by_zero !== 1'b0) begin
      errs++; $display("FAIL reset_outputs: dout=%h dbz=%b, required 0 0", dout, div_by_zero);
    end
    ap_rst = 1'b0;
    ce     = 1'b1;
    @(negedge ap_clk);
  endtask

  task automatic test_positive();
    start_op(32'd100, 8'd7);
    wait_done(0, 34, "pos");
    @(posedge ap_clk);
    @(negedge ap_clk);
    vectors++;
    if (ap_done !== 1'b0 || dout !== 32'd14) begin
      errs++; $display("FAIL pos_hold: done=%b dout=%h, required 0 and 0000000e", ap_done, dout);
    end
  endtask

  task automatic test_negative();
    start_op(32'hFFFFFF9C, 8'd7);
    wait_done(0, 34, "neg");
    start_op(32'hFFFFFFF7, 8'd2);
    wait_done(0, 34, "neg_small");
  endtask

  task automatic test_extremes();
    start_op(32'h80000000, 8'd1);
    wait_done(0, 34, "min_by_1");
    start_op(32'h7FFFFFFF, 8'd255);
    wait_done(0, 34, "max_by_255");
    start_op(32'hFFFFFFFF, 8'd255);
    wait_done(0, 34, "m1_by_255");
    start_op(32'h80000000, 8'd255);
    wait_done(0, 34, "min_by_255");
  endtask

  task automatic test_div_by_zero();
    start_op(32'd1234, 8'd0);
    wait_done(0, 34, "dbz_pos");
    start_op(32'hFFFFFFFB, 8'd0);
    wait_done(0, 34, "dbz_neg");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      start_op($urandom, 8'($urandom_range(1, 255)));
      wait_done(0, 34, "random");
    end
  endtask

  task automatic test_ce_stall();
    start_op(32'hFFFFFC18, 8'd13);
    repeat (10) @(negedge ap_clk);
    ce = 1'b0;
    repeat (10) @(negedge ap_clk);
    ce = 1'b1;
    wait_done(20, 44, "ce_stall");
    ce = 1'b0;
    repeat (3) @(negedge ap_clk);
    vectors++;
    if (ap_done !== 1'b1) begin errs++; $display("FAIL ce_done_stretch: got %b, required 1", ap_done); end
    ce = 1'b1;
    @(negedge ap_clk);
    vectors++;
    if (ap_done !== 1'b0) begin errs++; $display("FAIL ce_done_release: got %b, required 0", ap_done); end
  endtask

  task automatic test_back_to_back();
    int cyc   = 0;
    int extra = 0;
    wait_idle();
    din0 = 32'd100; din1 = 8'd7; ap_start = 1'b1;
    sb.push_back(model(32'd100, 8'd7));
    @(posedge ap_clk);
    @(negedge ap_clk);
    vectors++;
    if (ap_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready1: got %b, required 1", ap_ready); end
    while (ap_done !== 1'b1 && cyc < 60) begin
      @(posedge ap_clk);
      cyc++;
      @(negedge ap_clk);
      if (ap_ready === 1'b1 && ap_done !== 1'b1) extra++;
    end
    vectors++;
    if (extra != 0) begin errs++; $display("FAIL b2b_ignored_start: %0d extra ap_ready pulses, required 0", extra); end
    wait_done(cyc, 34, "b2b_first");
    din0 = 32'hFFFFFFF7; din1 = 8'd2;
    sb.push_back(model(32'hFFFFFFF7, 8'd2));
    @(posedge ap_clk);
    @(negedge ap_clk);
    vectors++;
    if (ap_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready2: got %b, required 1", ap_ready); end
    ap_start = 1'b0;
    wait_done(0, 34, "b2b_second");
  endtask

  task automatic test_reset_mid_op();
    int seen = 0;
    start_op(32'd5000, 8'd3);
    repeat (14) @(negedge ap_clk);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    void'(sb.pop_back());
    vectors++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin
      errs++; $display("FAIL midrst_state: idle=%b done=%b, required 1 0", ap_idle, ap_done);
    end
    vectors++;
    if (dout !== 32'd0 || div_by_zero !== 1'b0) begin
      errs++; $display("FAIL midrst_outputs: dout=%h dbz=%b, required 0 0", dout, div_by_zero);
    end
    repeat (45) begin
      @(negedge ap_clk);
      if (ap_done === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin errs++; $display("FAIL midrst_no_done: %0d ap_done cycles, required 0", seen); end
    start_op(32'd77, 8'd7);
    wait_done(0, 34, "after_rst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_positive();
    test_negative();
    test_extremes();
    test_div_by_zero();
    test_random();
    test_ce_stall();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
